// File: rtl/crypto_fifo_pkg.sv
// Shared definitions for the crypto datapath stream FIFOs.
// Contents:
//   FIFO_ADDR_WIDTH_DEF / FIFO_DATA_WIDTH_DEF : default geometry
//   fifo_ptr_t                                : pointer type (address bits plus wrap flag)
//   fifo_level()                              : occupancy from a write/read pointer pair
package crypto_fifo_pkg;

    localparam int unsigned FIFO_ADDR_WIDTH_DEF = 4;
    localparam int unsigned FIFO_DATA_WIDTH_DEF = 32;

    // Pointer for the default geometry: low bits address the RAM, MSB is the wrap flag.
    typedef logic [FIFO_ADDR_WIDTH_DEF:0] fifo_ptr_t;

    // Occupancy = (wr - rd) modulo 2^(addr_width+1). Pointers are passed zero-extended.
    function automatic int unsigned fifo_level(input int unsigned wr_ptr,
                                               input int unsigned rd_ptr,
                                               input int unsigned addr_width);
        int unsigned mask;
        mask = (32'd1 << (addr_width + 1)) - 32'd1;
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/simple_dpram_sclk.sv
// Single-clock dual-port RAM: one synchronous write port, one asynchronous read port.
// Ports:
//   i_clk              clock
//   i_we/i_waddr/i_din write port, written on the rising edge
//   i_raddr            read address
//   o_dout             read data, combinational from the array (or from i_din when
//                      ENABLE_BYPASS is set and the write hits the read address)
module simple_dpram_sclk #(
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          ENABLE_BYPASS = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_din;
        end
    end

    always_comb begin
        o_dout = r_mem[i_raddr];
        if (ENABLE_BYPASS && i_we && (i_waddr == i_raddr)) begin
            o_dout = i_din;
        end
    end

endmodule

// File: rtl/dpram_stream_fifo.sv
// Valid/ready first-word-fall-through FIFO over simple_dpram_sclk.
// Optional feature macro: DPRAM_FIFO_OUT_REG_EN adds a one-entry output register after the
// RAM read (registered out_valid/out_data, capacity DEPTH+1, 2-cycle write-to-read latency).
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_flush            synchronous clear of both pointers (RAM contents untouched)
//   i_in_valid/o_in_ready/i_in_data     producer stream
//   o_out_valid/i_out_ready/o_out_data  consumer stream
//   o_level            registered occupancy, 0..capacity
//   o_almost_full      registered, level >= AFULL_THRESH
module dpram_stream_fifo
    import crypto_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = FIFO_ADDR_WIDTH_DEF,
    parameter int unsigned DATA_WIDTH   = FIFO_DATA_WIDTH_DEF,
    parameter int unsigned AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_flush,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [DATA_WIDTH-1:0] i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [ADDR_WIDTH:0]   o_level,
    output logic                  o_almost_full
);

    localparam int unsigned PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      w_wr_nx;
    logic [PTR_W-1:0]      w_rd_nx;
    logic [PTR_W-1:0]      w_level_nx;
    logic [PTR_W-1:0]      r_level;
    logic                  r_afull;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_rd_adv;
    logic [DATA_WIDTH-1:0] w_ram_dout;

    // Empty/full describe the RAM only; the optional output register is tracked separately.
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0])
                        && (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
    assign o_in_ready = !w_full;
    assign w_push     = i_in_valid & o_in_ready;

`ifdef DPRAM_FIFO_OUT_REG_EN
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  w_load;
    logic                  w_out_valid_nx;

    // Reload whenever the register is empty or being drained, so a pop and a refill share
    // one edge and throughput stays at one word per cycle.
    assign w_load         = !w_empty && (!r_out_valid || i_out_ready);
    assign w_rd_adv       = w_load;
    assign w_out_valid_nx = w_load || (r_out_valid && !i_out_ready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_out_valid_nx;
            if (w_load) begin
                r_out_data <= w_ram_dout;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
`else
    assign o_out_valid = !w_empty;
    assign o_out_data  = w_ram_dout;
    assign w_rd_adv    = o_out_valid & i_out_ready;
`endif

    always_comb begin
        w_wr_nx = r_wr_ptr;
        w_rd_nx = r_rd_ptr;
        if (i_flush) begin
            w_wr_nx = '0;
            w_rd_nx = '0;
        end else begin
            if (w_push) begin
                w_wr_nx = r_wr_ptr + PTR_W'(1);
            end
            if (w_rd_adv) begin
                w_rd_nx = r_rd_ptr + PTR_W'(1);
            end
        end
    end

    always_comb begin
        w_level_nx = PTR_W'(fifo_level(32'(w_wr_nx), 32'(w_rd_nx), ADDR_WIDTH));
`ifdef DPRAM_FIFO_OUT_REG_EN
        w_level_nx = w_level_nx + PTR_W'(w_out_valid_nx & !i_flush);
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_afull  <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_nx;
            r_rd_ptr <= w_rd_nx;
            r_level  <= w_level_nx;
            r_afull  <= (32'(w_level_nx) >= AFULL_THRESH);
        end
    end

    assign o_level       = r_level;
    assign o_almost_full = r_afull;

    // A flushed push must not touch the RAM either.
    simple_dpram_sclk #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .ENABLE_BYPASS (1'b0)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_push & !i_flush),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_din   (i_in_data),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_dout  (w_ram_dout)
    );

endmodule

// File: tb/tb_dpram_stream_fifo.sv
// Self-checking bench for dpram_stream_fifo (ADDR_WIDTH = 2, DATA_WIDTH = 8, threshold 2).
// Default build: directed vector table, hand sequences, and randomized traffic against a
// queue model. With DPRAM_FIFO_OUT_REG_EN: output-register latency/capacity/throughput.
module tb_dpram_stream_fifo;

    localparam int unsigned AW    = 2;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned THR   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW:0]   level;
    logic          almost_full;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q[$];

    dpram_stream_fifo #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .AFULL_THRESH (THR)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_flush       (flush),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_level       (level),
        .o_almost_full (almost_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare all outputs against the queue model (occupancy and head word).
    task automatic model_cmp(input string tag);
        chk({tag, " level"}, 32'(level), q.size());
        chk({tag, " in_ready"}, 32'(in_ready), 32'(q.size() < DEPTH));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(q.size() > 0));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(q.size() >= THR));
        if (q.size() > 0) chk({tag, " out_data"}, 32'(out_data), 32'(q[0]));
    endtask

    // One clock with the given inputs; the model applies the FIFO rules to its queue.
    task automatic cyc(input logic v, input logic r, input logic f, input logic [DW-1:0] d,
                       input string tag);
        bit push;
        bit pop;
        in_valid  = v;
        out_ready = r;
        flush     = f;
        in_data   = d;
        #1;
        push = v && (q.size() < DEPTH);
        pop  = r && (q.size() > 0);
        if (pop) chk({tag, " pop_data"}, 32'(out_data), 32'(q[0]));
        @(posedge clk);
        #1;
        if (f) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        model_cmp(tag);
    endtask

    task automatic drv(input logic v, input logic r, input logic [DW-1:0] d);
        in_valid  = v;
        out_ready = r;
        in_data   = d;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic          v;
        logic          r;
        logic          f;
        logic [DW-1:0] d;
        int            lvl;
        logic          ir;
        logic          ov;
        logic          af;
        logic          dc;
        logic [DW-1:0] od;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h0A, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h0A};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h0B, 2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h0C, 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0A};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h0D, 4, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0A};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h0E, 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0B};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h0E, 4, 1'b0, 1'b1, 1'b1, 1'b1, 8'h0B};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 1'b1, 1'b1, 1'b1, 1'b1, 8'h0C};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h0F, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h55, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h55};
        tbl[9] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        repeat (2) @(posedge clk);
        #1;
        chk("reset level", 32'(level), 0);
        chk("reset in_ready", 32'(in_ready), 1);
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset almost_full", 32'(almost_full), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifndef DPRAM_FIFO_OUT_REG_EN
        // Fill, full-with-pop, flush colliding with push/pop, post-flush ordering.
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].v, tbl[i].r, tbl[i].f, tbl[i].d, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_level", i), 32'(level), tbl[i].lvl);
            chk($sformatf("vec%0d tbl_in_ready", i), 32'(in_ready), 32'(tbl[i].ir));
            chk($sformatf("vec%0d tbl_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("vec%0d tbl_afull", i), 32'(almost_full), 32'(tbl[i].af));
            if (tbl[i].dc) chk($sformatf("vec%0d tbl_out_data", i), 32'(out_data),
                               32'(tbl[i].od));
        end

        // Streaming push+pop through several pointer wraps.
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 8'(i), $sformatf("stream%0d", i));
            chk($sformatf("stream%0d level_le1", i), 32'(level <= 1), 1);
        end
        cyc(1'b0, 1'b1, 1'b0, 8'h00, "stream_drain");

        // Asynchronous reset mid-burst at level 2.
        cyc(1'b1, 1'b0, 1'b0, 8'h21, "rb0");
        cyc(1'b1, 1'b0, 1'b0, 8'h22, "rb1");
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("async_rst out_valid", 32'(out_valid), 0);
        chk("async_rst level", 32'(level), 0);
        chk("async_rst in_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1'b1, 1'b0, 1'b0, 8'h77, "post_rst push");
        chk("post_rst first word", 32'(out_data), 32'h77);
        cyc(1'b0, 1'b1, 1'b0, 8'h00, "post_rst pop");

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 5),
                1'($urandom_range(0, 99) < 3), 8'($urandom), $sformatf("rnd%0d", i));
        end
`else
        begin
            int n;
            // Single push: visible two edges later.
            drv(1'b1, 1'b0, 8'h99);
            chk("oreg lat1 out_valid", 32'(out_valid), 0);
            chk("oreg lat1 level", 32'(level), 1);
            drv(1'b0, 1'b0, 8'h00);
            chk("oreg lat2 out_valid", 32'(out_valid), 1);
            chk("oreg lat2 out_data", 32'(out_data), 32'h99);
            drv(1'b0, 1'b1, 8'h00);
            chk("oreg pop out_valid", 32'(out_valid), 0);
            chk("oreg pop level", 32'(level), 0);
            // Fill until refused: capacity is DEPTH+1.
            n = 0;
            for (int k = 0; k < 20; k++) begin
                in_valid = 1'b1;
                in_data  = 8'(k);
                #1;
                if (!in_ready) break;
                @(posedge clk);
                #1;
                n++;
            end
            in_valid = 1'b0;
            chk("oreg capacity", n, DEPTH + 1);
            chk("oreg full level", 32'(level), DEPTH + 1);
            chk("oreg full afull", 32'(almost_full), 1);
            // Drain at one word per cycle.
            for (int k = 0; k <= DEPTH; k++) begin
                out_ready = 1'b1;
                #1;
                chk($sformatf("oreg drain%0d valid", k), 32'(out_valid), 1);
                chk($sformatf("oreg drain%0d data", k), 32'(out_data), k);
                @(posedge clk);
                #1;
            end
            out_ready = 1'b0;
            chk("oreg drained out_valid", 32'(out_valid), 0);
            chk("oreg drained level", 32'(level), 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
